// File: rtl/keypad_encoder_8_3.sv
// keypad_encoder_8_3
//   Samples eight active-low key/request lines, then synchronises and debounces them.
//   Each new press is priority-encoded (lowest index wins) and handed downstream as
//   one code per press over a valid/ready handshake.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   IDLE     | no key down in the debounced vector, waiting for a press
//   HOLD     | code/multi captured and presented, waiting for ready
//   WAIT_REL | event accepted, waiting for every key to be released
//
// Ports
//   clk    in   1  system clock, rising edge
//   rst    in   1  synchronous reset, active-high
//   in_n   in   8  asynchronous active-low key lines (bit i low = key i pressed)
//   code   out  3  index of the lowest pressed key in the captured vector
//   multi  out  1  more than one key pressed in the captured vector
//   valid  out  1  code/multi valid, held until accepted
//   ready  in   1  consumer accept (valid && ready on a rising edge)
//   busy   out  1  high in HOLD and WAIT_REL
module keypad_encoder_8_3 #(
  parameter  int DEB_CYCLES = 16,
  localparam int CNT_W      = $clog2(DEB_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_n,
  output logic [2:0] code,
  output logic       multi,
  output logic       valid,
  input  logic       ready,
  output logic       busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEB_CYCLES);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD     = 2'd1,
    WAIT_REL = 2'd2
  } state_t;

  state_t           state;
  logic [7:0]       s1;
  logic [7:0]       s2;
  logic [7:0]       s2_prev;
  logic [7:0]       deb;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       code_next;
  logic             multi_next;
  logic [3:0]       nzero;

  // Two-flop synchroniser followed by the stability counter. The debounced
  // vector takes s2 on the edge where the counter would step from DEB_CYCLES-1
  // to DEB_CYCLES, i.e. after DEB_CYCLES+1 identical consecutive s2 samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1      <= 8'hFF;
      s2      <= 8'hFF;
      s2_prev <= 8'hFF;
      deb     <= 8'hFF;
      cnt     <= '0;
    end else begin
      s1      <= in_n;
      s2      <= s1;
      s2_prev <= s2;
      if (s2 != s2_prev) begin
        cnt <= '0;
      end else begin
        if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
        if (cnt == CNT_LAST) deb <= s2;
      end
    end
  end

  // Priority encode: scanning downwards so the lowest pressed index is the
  // last assignment and therefore wins.
  always_comb begin
    code_next = 3'd0;
    nzero     = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      if (!deb[i]) begin
        code_next = 3'(i);
        nzero     = nzero + 4'd1;
      end
    end
    multi_next = (nzero > 4'd1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      code  <= 3'd0;
      multi <= 1'b0;
      valid <= 1'b0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (deb != 8'hFF) begin
            code  <= code_next;
            multi <= multi_next;
            valid <= 1'b1;
            busy  <= 1'b1;
            state <= HOLD;
          end
        end
        HOLD: begin
          // valid is always high here; code/multi stay frozen whatever the keys do
          if (ready) begin
            valid <= 1'b0;
            state <= WAIT_REL;
          end
        end
        WAIT_REL: begin
          if (deb == 8'hFF) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
